// File: rtl/sysarr_pkg.sv
// Shared definitions for the sysarr systolic multiplier and its result-side collector.
package sysarr_pkg;

    localparam int unsigned DEF_N   = 32;
    localparam int unsigned DEF_LAT = 5;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StWait = 3'd1,
        StCap0 = 3'd2,
        StCap1 = 3'd3,
        StCap2 = 3'd4,
        StHold = 3'd5
    } drain_state_e;

    // Wide enough to hold LAT-2, the initial WAIT count.
    function automatic int unsigned cnt_width(input int unsigned lat);
        return $clog2(lat);
    endfunction

endpackage

// File: rtl/sysarr_drain.sv
// De-skews the diagonal result stream of the 3x3 systolic array into a registered
// matrix and presents it with a valid/ready handshake.
module sysarr_drain
    import sysarr_pkg::*;
#(
    parameter int unsigned N   = DEF_N,
    parameter int unsigned LAT = DEF_LAT
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] c53,
    input  logic [N-1:0] c54,
    input  logic [N-1:0] c55,
    input  logic [N-1:0] c35,
    input  logic [N-1:0] c45,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [N-1:0] d00,
    output logic [N-1:0] d01,
    output logic [N-1:0] d02,
    output logic [N-1:0] d10,
    output logic [N-1:0] d11,
    output logic [N-1:0] d12,
    output logic [N-1:0] d20,
    output logic [N-1:0] d21,
    output logic [N-1:0] d22,
    output logic         busy,
    output logic         overrun
);

    localparam int unsigned CW = cnt_width(LAT);
    // WAIT lasts LAT-1 cycles so CAP0 samples on edge E0+LAT.
    localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 2);

    drain_state_e   state;
    logic [CW-1:0]  cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= StIdle;
            cnt       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            d00 <= '0; d01 <= '0; d02 <= '0;
            d10 <= '0; d11 <= '0; d12 <= '0;
            d20 <= '0; d21 <= '0; d22 <= '0;
        end else begin
            if (start && (state == StWait || state == StCap0 ||
                          state == StCap1 || state == StCap2)) begin
                overrun <= 1'b1;
            end
            case (state)
                StIdle: begin
                    if (start) begin
                        state <= StWait;
                        cnt   <= CNT_INIT;
                        busy  <= 1'b1;
                    end
                end
                StWait: begin
                    if (cnt == '0) begin
                        state <= StCap0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StCap0: begin
                    d00   <= c55;
                    d01   <= c45;
                    d02   <= c35;
                    d10   <= c54;
                    d20   <= c53;
                    state <= StCap1;
                end
                StCap1: begin
                    d11   <= c55;
                    d12   <= c45;
                    d21   <= c54;
                    state <= StCap2;
                end
                StCap2: begin
                    d22       <= c55;
                    state     <= StHold;
                    busy      <= 1'b0;
                    out_valid <= 1'b1;
                end
                StHold: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (start) begin
                            state <= StWait;
                            cnt   <= CNT_INIT;
                            busy  <= 1'b1;
                        end else begin
                            state <= StIdle;
                        end
                    end else if (start) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state     <= StIdle;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
